nonce_search_ctrl: RTL and testbench
====================================

NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

Interface
REQ-001 Parameter HEADER_W, default 96, SHALL set the fixed block-header width in bits.
REQ-002 Parameter NONCE_W, default 32, SHALL set the nonce width in bits.
REQ-003 Parameter HASH_W, default 24, SHALL set the hash-result width in bits.
REQ-004 Parameter TARGET_W, default 8, SHALL set the target width in bits; TARGET_W <= HASH_W.
REQ-005 Parameter LANES, default 2, SHALL set the number of parallel hash lanes; LANES >= 1.
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-008 Port start, input, 1, SHALL request a new search when sampled high in IDLE.
REQ-009 Port abort, input, 1, SHALL cancel any search in progress.
REQ-010 Port header, input, HEADER_W, SHALL carry the header, latched at start.
REQ-011 Port start_nonce, input, NONCE_W, SHALL carry the first nonce, latched at start.
REQ-012 Port target, input, TARGET_W, SHALL carry the difficulty target, latched at start.
REQ-013 Port lane_valid, output, LANES, SHALL pulse per lane for one cycle to issue a block.
REQ-014 Port lane_block, output, LANES*(HEADER_W+NONCE_W), SHALL carry per lane i the block {header, nonce_i} in slice i.
REQ-015 Port lane_hash_valid, input, LANES, SHALL mark a returned hash per lane.
REQ-016 Port lane_hash, input, LANES*HASH_W, SHALL carry per lane i the returned hash in slice i.
REQ-017 Port busy, output, 1; done, output, 1; found, output, 1 SHALL report status.
REQ-018 Port found_nonce, output, NONCE_W; found_hash, output, HASH_W SHALL report the winning result.
REQ-019 Port attempts, output, NONCE_W+1, SHALL count hashes evaluated in the current search.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, CHECK, FINISH.
REQ-021 IDLE: start=1 SHALL latch header/start_nonce/target, set base=start_nonce, clear attempts and found, and go to ISSUE next cycle; busy=1 in all states except IDLE.
REQ-022 ISSUE: lane i SHALL use nonce_i = base+i; lane enabled only if base+i <= 2^NONCE_W-1 (no carry); lane_valid[i]=1 for exactly one cycle for enabled lanes; then go to WAIT.
REQ-023 lane_block slices SHALL hold stable from ISSUE until the next ISSUE or IDLE.
REQ-024 WAIT: a per-lane pending bit set at ISSUE SHALL be cleared and the hash captured on lane_hash_valid[i]; lane_hash_valid on a non-pending lane SHALL be ignored; go to CHECK once no bits are pending.
REQ-025 Lane i SHALL pass when the top TARGET_W bits of its hash, unsigned, are strictly less than target.
REQ-026 CHECK: attempts SHALL increase by the number of enabled lanes; if any passes, the lowest-index passing lane SHALL load found_nonce/found_hash, set found=1, go to FINISH.
REQ-027 CHECK with no pass: if base+LANES overflows NONCE_W bits, go to FINISH with found=0 (exhausted); else base+=LANES, go to ISSUE.
REQ-028 FINISH: done=1 for exactly one cycle, then IDLE; found/found_nonce/found_hash SHALL hold until the next accepted start or reset.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, clear pending bits, suppress lane_valid, not assert done; abort overrides same-cycle hash returns; results SHALL hold.
REQ-030 start outside IDLE SHALL be ignored; start and abort together in IDLE SHALL be ignored.

Reset
REQ-031 reset=1 SHALL, next edge, force IDLE and zero busy, done, found, found_nonce, found_hash, attempts, lane_valid, lane_block, pending bits and base, overriding every other input, including mid-search.

Verification
REQ-032 LANES=2, start_nonce=0x10, target=0x40, hashes top bytes {0x80,0x80} then {0x90,0x20} -> second ISSUE uses nonces 0x12/0x13; found=1, found_nonce=0x13, attempts=4, done one cycle.
REQ-033 Both lanes pass, top bytes {0x10,0x05} -> found_nonce=base+0 (lowest lane wins, not lowest hash).
REQ-034 NONCE_W=4, LANES=2, start_nonce=0xF, no pass -> only lane 0 issued (nonce 0xF), attempts=1, done=1, found=0.
REQ-035 Lane 1 returns 3 cycles before lane 0; spurious lane_hash_valid in IDLE -> CHECK only after both return; spurious pulse has no effect.
REQ-036 abort during WAIT with same-cycle lane_hash_valid -> IDLE next cycle, done never asserted, busy=0; a subsequent start runs normally.
REQ-037 reset asserted in WAIT -> all outputs 0 next cycle; start accepted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: issues nonce blocks to parallel hash lanes and stops on the first hash below target
module nonce_search_ctrl #(
  parameter int HEADER_W = 96,
  parameter int NONCE_W = 32,
  parameter int HASH_W = 24,
  parameter int TARGET_W = 8,
  parameter int LANES = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [HEADER_W-1:0]              header,
  input  logic [NONCE_W-1:0]               start_nonce,
  input  logic [TARGET_W-1:0]              target,
  output logic [LANES-1:0]                 lane_valid,
  output logic [LANES*(HEADER_W+NONCE_W)-1:0] lane_block,
  input  logic [LANES-1:0]                 lane_hash_valid,
  input  logic [LANES*HASH_W-1:0]          lane_hash,
  output logic                             busy,
  output logic                             done,
  output logic                             found,
  output logic [NONCE_W-1:0]               found_nonce,
  output logic [HASH_W-1:0]                found_hash,
  output logic [NONCE_W:0]                 attempts
);
  localparam int BW = HEADER_W + NONCE_W;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;
  state_t state, state_nx;
  logic [HEADER_W-1:0] hdr;
  logic [NONCE_W-1:0] base, win_nonce;
  logic [TARGET_W-1:0] tgt;
  logic [LANES-1:0] en, pending, pass, left;
  logic [LANES*HASH_W-1:0] hashes;
  logic [HASH_W-1:0] win_hash;
  logic [NONCE_W:0] next_base, cnt, sum;
  assign next_base = {1'b0, base} + (NONCE_W+1)'(LANES);
  assign left = pending & ~lane_hash_valid;
  assign busy = state != IDLE;
  assign done = state == FINISH && !abort;
  assign lane_valid = (state == ISSUE && !abort) ? en : '0;
  always_comb begin
    en = '0;
    pass = '0;
    cnt = '0;
    sum = '0;
    win_nonce = '0;
    win_hash = '0;
    lane_block = '0;
    // descending scan so the lowest passing lane is the last to write the winner
    for (int i = LANES - 1; i >= 0; i--) begin
      sum = {1'b0, base} + (NONCE_W+1)'(i);
      en[i] = !sum[NONCE_W];
      lane_block[i*BW +: BW] = state == IDLE ? '0 : {hdr, sum[NONCE_W-1:0]};
      pass[i] = en[i] && hashes[i*HASH_W + HASH_W - TARGET_W +: TARGET_W] < tgt;
      cnt = cnt + (NONCE_W+1)'(en[i]);
      if (pass[i]) begin
        win_nonce = sum[NONCE_W-1:0];
        win_hash = hashes[i*HASH_W +: HASH_W];
      end
    end
  end
  always_comb begin
    state_nx = abort ? IDLE
      : state == IDLE ? (start ? ISSUE : IDLE)
      : state == ISSUE ? WAIT
      : state == WAIT ? (left == '0 ? CHECK : WAIT)
      : state == CHECK ? ((|pass || next_base[NONCE_W]) ? FINISH : ISSUE)
      : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hdr <= '0;
      base <= '0;
      tgt <= '0;
      pending <= '0;
      hashes <= '0;
      found <= 1'b0;
      found_nonce <= '0;
      found_hash <= '0;
      attempts <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !abort) begin
        hdr <= header;
        base <= start_nonce;
        tgt <= target;
        attempts <= '0;
        found <= 1'b0;
        found_nonce <= '0;
        found_hash <= '0;
      end
      if (abort) begin
        pending <= '0;
      end else if (state == ISSUE) begin
        pending <= en;
      end else if (state == WAIT) begin
        pending <= left;
        for (int i = 0; i < LANES; i++)
          if (pending[i] && lane_hash_valid[i]) hashes[i*HASH_W +: HASH_W] <= lane_hash[i*HASH_W +: HASH_W];
      end else if (state == CHECK) begin
        attempts <= attempts + cnt;
        if (|pass) begin
          found <= 1'b1;
          found_nonce <= win_nonce;
          found_hash <= win_hash;
        end else if (!next_base[NONCE_W]) begin
          base <= next_base[NONCE_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb_nonce_search_ctrl: directed scenarios with hand-computed expectations for a 32-bit and a 4-bit nonce instance
module tb_nonce_search_ctrl;
  logic clk = 0, reset = 1, start = 0, start4 = 0, abort = 0;
  logic [95:0] header = 96'h0123_4567_89AB_CDEF_F00D_CAFE;
  logic [31:0] start_nonce = '0;
  logic [3:0] start_nonce4 = '0;
  logic [7:0] target = '0;
  logic [1:0] lane_hash_valid = '0;
  logic [47:0] lane_hash = '0;
  logic [1:0] lane_valid, lane_valid4;
  logic [255:0] lane_block;
  logic [199:0] lane_block4;
  logic busy, done, found, busy4, done4, found4;
  logic [31:0] found_nonce;
  logic [3:0] found_nonce4;
  logic [23:0] found_hash, found_hash4;
  logic [32:0] attempts;
  logic [4:0] attempts4;
  int n = 0, nf = 0;

  nonce_search_ctrl dut (.clk(clk), .reset(reset), .start(start), .abort(abort), .header(header),
    .start_nonce(start_nonce), .target(target), .lane_valid(lane_valid), .lane_block(lane_block),
    .lane_hash_valid(lane_hash_valid), .lane_hash(lane_hash), .busy(busy), .done(done), .found(found),
    .found_nonce(found_nonce), .found_hash(found_hash), .attempts(attempts));

  nonce_search_ctrl #(.NONCE_W(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .abort(abort),
    .header(header), .start_nonce(start_nonce4), .target(target), .lane_valid(lane_valid4),
    .lane_block(lane_block4), .lane_hash_valid(lane_hash_valid), .lane_hash(lane_hash), .busy(busy4),
    .done(done4), .found(found4), .found_nonce(found_nonce4), .found_hash(found_hash4), .attempts(attempts4));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [1:0] v, input logic [23:0] h0, input logic [23:0] h1);
    lane_hash_valid = v;
    lane_hash = {h1, h0};
    step();
    lane_hash_valid = '0;
  endtask

  task automatic go(input logic [31:0] sn);
    start_nonce = sn;
    target = 8'h40;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    n++; if (busy !== 1'b0) begin nf++; $display("FAIL reset_busy got=%h exp=0", busy); end
    n++; if (done !== 1'b0) begin nf++; $display("FAIL reset_done got=%h exp=0", done); end
    n++; if (found !== 1'b0) begin nf++; $display("FAIL reset_found got=%h exp=0", found); end
    n++; if (attempts !== 33'd0) begin nf++; $display("FAIL reset_attempts got=%h exp=0", attempts); end
    n++; if (lane_valid !== 2'b00) begin nf++; $display("FAIL reset_lane_valid got=%h exp=0", lane_valid); end
    n++; if (lane_block !== 256'd0) begin nf++; $display("FAIL reset_lane_block got=%h exp=0", lane_block); end
    reset = 0;
  endtask

  task automatic test_find();
    go(32'h10);
    n++; if (lane_valid !== 2'b11) begin nf++; $display("FAIL find_issue1 got=%h exp=3", lane_valid); end
    n++; if (lane_block[127:0] !== {header, 32'h10}) begin nf++; $display("FAIL find_blk0 got=%h exp=%h", lane_block[127:0], {header, 32'h10}); end
    n++; if (lane_block[255:128] !== {header, 32'h11}) begin nf++; $display("FAIL find_blk1 got=%h exp=%h", lane_block[255:128], {header, 32'h11}); end
    start = 1;
    step();
    start = 0;
    n++; if (lane_valid !== 2'b00) begin nf++; $display("FAIL find_valid_pulse got=%h exp=0", lane_valid); end
    ret(2'b11, 24'h80_0001, 24'h80_0002);
    step();
    n++; if (lane_valid !== 2'b11) begin nf++; $display("FAIL find_issue2 got=%h exp=3", lane_valid); end
    n++; if (lane_block[31:0] !== 32'h12) begin nf++; $display("FAIL find_nonce0 got=%h exp=12", lane_block[31:0]); end
    n++; if (lane_block[159:128] !== 32'h13) begin nf++; $display("FAIL find_nonce1 got=%h exp=13", lane_block[159:128]); end
    n++; if (attempts !== 33'd2) begin nf++; $display("FAIL find_attempts_mid got=%0d exp=2", attempts); end
    step();
    ret(2'b11, 24'h90_0000, 24'h20_ABCD);
    step();
    n++; if (done !== 1'b1) begin nf++; $display("FAIL find_done got=%h exp=1", done); end
    n++; if (found !== 1'b1) begin nf++; $display("FAIL find_found got=%h exp=1", found); end
    n++; if (found_nonce !== 32'h13) begin nf++; $display("FAIL find_nonce got=%h exp=13", found_nonce); end
    n++; if (found_hash !== 24'h20_ABCD) begin nf++; $display("FAIL find_hash got=%h exp=20abcd", found_hash); end
    n++; if (attempts !== 33'd4) begin nf++; $display("FAIL find_attempts got=%0d exp=4", attempts); end
    step();
    n++; if (done !== 1'b0 || busy !== 1'b0) begin nf++; $display("FAIL find_idle got=%h%h exp=00", done, busy); end
    n++; if (found !== 1'b1 || found_nonce !== 32'h13) begin nf++; $display("FAIL find_hold got=%h/%h exp=1/13", found, found_nonce); end
  endtask

  task automatic test_lowest_lane();
    go(32'h100);
    step();
    ret(2'b11, 24'h10_0000, 24'h05_0000);
    step();
    n++; if (found_nonce !== 32'h100) begin nf++; $display("FAIL lowest_nonce got=%h exp=100", found_nonce); end
    n++; if (found_hash !== 24'h10_0000) begin nf++; $display("FAIL lowest_hash got=%h exp=100000", found_hash); end
    n++; if (attempts !== 33'd2) begin nf++; $display("FAIL lowest_attempts got=%0d exp=2", attempts); end
    step();
  endtask

  task automatic test_exhaust();
    start_nonce4 = 4'hF;
    target = 8'h40;
    start4 = 1;
    step();
    start4 = 0;
    n++; if (lane_valid4 !== 2'b01) begin nf++; $display("FAIL exh_issue got=%h exp=1", lane_valid4); end
    n++; if (lane_block4[3:0] !== 4'hF) begin nf++; $display("FAIL exh_nonce got=%h exp=f", lane_block4[3:0]); end
    step();
    ret(2'b11, 24'h80_0000, 24'h00_0000);
    step();
    n++; if (done4 !== 1'b1) begin nf++; $display("FAIL exh_done got=%h exp=1", done4); end
    n++; if (found4 !== 1'b0) begin nf++; $display("FAIL exh_found got=%h exp=0", found4); end
    n++; if (attempts4 !== 5'd1) begin nf++; $display("FAIL exh_attempts got=%0d exp=1", attempts4); end
    step();
    n++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin nf++; $display("FAIL exh_idle got=%h%h exp=00", done4, busy4); end
  endtask

  task automatic test_out_of_order();
    ret(2'b11, 24'h00_0000, 24'h00_0000);
    n++; if (busy !== 1'b0 || found_nonce !== 32'h100) begin nf++; $display("FAIL spur_idle got=%h/%h exp=0/100", busy, found_nonce); end
    go(32'h20);
    step();
    ret(2'b10, 24'hFF_FFFF, 24'h30_0000);
    for (int k = 0; k < 2; k++) begin
      n++; if (done !== 1'b0 || busy !== 1'b1) begin nf++; $display("FAIL ooo_wait%0d got=%h%h exp=01", k, done, busy); end
      step();
    end
    ret(2'b01, 24'h50_0000, 24'h00_0000);
    step();
    n++; if (done !== 1'b1) begin nf++; $display("FAIL ooo_done got=%h exp=1", done); end
    n++; if (found_nonce !== 32'h21) begin nf++; $display("FAIL ooo_nonce got=%h exp=21", found_nonce); end
    step();
  endtask

  task automatic test_abort();
    go(32'h40);
    step();
    abort = 1;
    lane_hash_valid = 2'b11;
    lane_hash = '0;
    step();
    abort = 0;
    lane_hash_valid = '0;
    n++; if (busy !== 1'b0 || done !== 1'b0) begin nf++; $display("FAIL abort_idle got=%h%h exp=00", busy, done); end
    n++; if (found !== 1'b0 || attempts !== 33'd0) begin nf++; $display("FAIL abort_result got=%h/%0d exp=0/0", found, attempts); end
    step();
    n++; if (done !== 1'b0 || lane_valid !== 2'b00) begin nf++; $display("FAIL abort_quiet got=%h/%h exp=0/0", done, lane_valid); end
    go(32'h50);
    n++; if (lane_valid !== 2'b11) begin nf++; $display("FAIL abort_restart got=%h exp=3", lane_valid); end
    step();
    ret(2'b11, 24'h40_0000, 24'h3F_FFFF);
    step();
    n++; if (done !== 1'b1 || found_nonce !== 32'h51) begin nf++; $display("FAIL abort_rerun got=%h/%h exp=1/51", done, found_nonce); end
    step();
  endtask

  task automatic test_reset_mid();
    go(32'h60);
    step();
    reset = 1;
    step();
    n++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin nf++; $display("FAIL rmid_flags got=%h%h%h exp=000", busy, done, found); end
    n++; if (found_nonce !== 32'd0 || found_hash !== 24'd0 || attempts !== 33'd0) begin nf++; $display("FAIL rmid_results got=%h/%h/%h exp=0/0/0", found_nonce, found_hash, attempts); end
    n++; if (lane_valid !== 2'b00 || lane_block !== 256'd0) begin nf++; $display("FAIL rmid_lanes got=%h/%h exp=0/0", lane_valid, lane_block); end
    reset = 0;
    go(32'h70);
    n++; if (lane_valid !== 2'b11 || busy !== 1'b1) begin nf++; $display("FAIL rmid_start got=%h/%h exp=3/1", lane_valid, busy); end
    step();
    ret(2'b11, 24'h01_0000, 24'h80_0000);
    step();
    n++; if (found_nonce !== 32'h70 || done !== 1'b1) begin nf++; $display("FAIL rmid_run got=%h/%h exp=70/1", found_nonce, done); end
    step();
  endtask

  task automatic test_start_abort_idle();
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    n++; if (busy !== 1'b0 || lane_valid !== 2'b00) begin nf++; $display("FAIL start_abort got=%h/%h exp=0/0", busy, lane_valid); end
  endtask

  initial begin
    test_reset();
    test_find();
    test_lowest_lane();
    test_exhaust();
    test_out_of_order();
    test_abort();
    test_reset_mid();
    test_start_abort_idle();
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
